// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - pixel RAM arbiter: display scan first, CPU requests queued in order
//
// Ports:
//   vga_clk, rst                    pixel clock, synchronous active-high reset
//   disp_rdn, disp_row, disp_col    display read request (active low) and its address
//   disp_data                       pixel to the VGA controller (copy of ram_rdata)
//   cpu_req, cpu_we, cpu_addr,      CPU request, pushed when cpu_req && cpu_ready
//   cpu_wdata, cpu_ready
//   cpu_rvalid, cpu_rdata           one-cycle read completion pulse and its data
//   fifo_count                      request FIFO occupancy
//   ram_addr, ram_we, ram_wdata,    pixel RAM port (asynchronous read, write at posedge)
//   ram_rdata
module vram_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 19,
    parameter int DW    = 8
) (
    input  logic                       vga_clk,
    input  logic                       rst,
    input  logic                       disp_rdn,
    input  logic [8:0]                 disp_row,
    input  logic [9:0]                 disp_col,
    output logic [DW-1:0]              disp_data,
    input  logic                       cpu_req,
    input  logic                       cpu_we,
    input  logic [AW-1:0]              cpu_addr,
    input  logic [DW-1:0]              cpu_wdata,
    output logic                       cpu_ready,
    output logic                       cpu_rvalid,
    output logic [DW-1:0]              cpu_rdata,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [AW-1:0]              ram_addr,
    output logic                       ram_we,
    output logic [DW-1:0]              ram_wdata,
    input  logic [DW-1:0]              ram_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic          q_we    [DEPTH];
    logic [AW-1:0] q_addr  [DEPTH];
    logic [DW-1:0] q_wdata [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic head_we;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head_we = q_we[rd_ptr];

    // Readiness depends only on occupancy, so a pop in the same cycle
    // never opens room for a push into a full FIFO.
    assign cpu_ready = !rst && !full;
    assign push      = cpu_req && cpu_ready;

    // CPU slot: display idle and something queued. Gating with rst keeps
    // an in-service request from completing across a reset edge.
    assign pop = !rst && disp_rdn && !empty;

    assign disp_data  = ram_rdata;
    assign fifo_count = count;

    always_comb begin
        ram_addr  = AW'({disp_row, disp_col});
        ram_we    = 1'b0;
        ram_wdata = q_wdata[rd_ptr];
        if (pop) begin
            ram_addr = q_addr[rd_ptr];
            ram_we   = head_we;
        end
    end

    // Entry storage needs no reset: occupancy alone decides validity.
    always_ff @(posedge vga_clk) begin
        if (push) begin
            q_we[wr_ptr]    <= cpu_we;
            q_addr[wr_ptr]  <= cpu_addr;
            q_wdata[wr_ptr] <= cpu_wdata;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            cpu_rvalid <= pop && !head_we;
            if (pop && !head_we) begin
                cpu_rdata <= ram_rdata;
            end
        end
    end

endmodule
